ordenador_seq: RTL and testbench
================================

ORDENADOR_SEQ -- requirements
Module: ordenador_seq

Interface
REQ-001 Parameter: WIDTH, default 4, bit width of each sorted value.
REQ-002 clk  input  1  rising-edge clock; sole clock of the block.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 in_valid  input  1  producer presents in_data.
REQ-005 in_ready  output  1  block accepts in_data this cycle.
REQ-006 in_data  input  WIDTH  unsigned value to be sorted.
REQ-007 out_valid  output  1  out_data holds a sorted value.
REQ-008 out_ready  input  1  consumer accepts out_data this cycle.
REQ-009 out_data  output  WIDTH  sorted value, one per beat.
REQ-010 out_last  output  1  high with the third (final) beat of a group.

Function
REQ-011 The block SHALL accept groups of exactly three values serially and emit them serially in descending order, so the first beat is the largest and the third is the smallest.
REQ-012 Handshake on either port SHALL occur only on a cycle where valid and ready are both high at the rising edge of clk.
REQ-013 States: LOAD, SORT, EMIT; LOAD is the reset state.
REQ-014 LOAD: in_ready=1, out_valid=0; each input handshake writes in_data to r[cnt] and increments the 2-bit cnt; the third handshake moves to SORT with cnt cleared.
REQ-015 SORT: SHALL last exactly 3 cycles with in_ready=0 and out_valid=0, performing compare-exchange on (r0,r1), then (r1,r2), then (r0,r1), one pair per cycle.
REQ-016 A compare-exchange SHALL swap only when the strict ordering test fails (r_lo < r_hi for descending), so equal values are never swapped.
REQ-017 Comparisons SHALL be unsigned over the full WIDTH bits.
REQ-018 EMIT: out_valid=1, out_data=r[cnt], out_last=1 only when cnt=2, in_ready=0; each output handshake increments cnt.
REQ-019 The output handshake with out_last=1 SHALL return to LOAD with cnt=0, and in_ready SHALL be 1 on the next cycle.
REQ-020 Latency: if the third input handshake is at edge T, out_valid SHALL first be high in the cycle following edge T+3, with no dependence on data.
REQ-021 While out_valid=1 and out_ready=0, out_data and out_last SHALL remain stable.
REQ-022 in_valid SHALL be ignored outside LOAD, and no input data is lost or overwritten.
REQ-023 Throughput: one group per at least 3 + 3 + 3 = 9 cycles when out_ready is held high.

Reset
REQ-024 When rst_n=0 at a rising edge, the next state SHALL be LOAD with cnt=0, in_ready=1, out_valid=0, out_last=0, out_data=0, and r0..r2=0.
REQ-025 Reset mid-group, in any state, SHALL discard the partial group, and no stale beat SHALL be emitted afterwards.

Configuration
REQ-026 Macro ORDENADOR_SEQ_ASCEND_EN: when defined, the output order SHALL be ascending (smallest first, swap when r_lo > r_hi), with all timing unchanged.
REQ-027 When ORDENADOR_SEQ_ASCEND_EN is undefined, the output order SHALL be descending as specified above.

Verification
REQ-028 Reset, then inputs 3, 9, 5 with out_ready=1 -> outputs 9, 5, 3; out_last only on 3; first out_valid in the 4th cycle after the third input edge.
REQ-029 Inputs 2, 2, 7 -> outputs 7, 2, 2; inputs 15, 0, 15 -> outputs 15, 15, 0 (equal values and full-range boundary).
REQ-030 Inputs 1, 4, 8 with out_ready low for 5 cycles in EMIT -> out_data holds 8 and out_last holds 0 throughout the stall, then 8, 4, 1 is emitted.
REQ-031 Pulse in_valid with data 12 during SORT and EMIT of a group 6, 1, 3 -> the value 12 is never accepted and the output is 6, 3, 1.
REQ-032 Assert rst_n=0 after two inputs (5, 7) -> all outputs take reset values; the next group 4, 11, 0 emits 11, 4, 0.
REQ-033 With ORDENADOR_SEQ_ASCEND_EN defined, inputs 3, 9, 5 -> outputs 3, 5, 9, with latency identical to REQ-028.

Source files
------------

// File: rtl/ordenador_seq.sv
// ordenador_seq: accepts three values serially, sorts them, and emits them
// serially. The default order is descending (largest first). If the macro
// ORDENADOR_SEQ_ASCEND_EN is defined, the order is ascending instead and the
// timing stays the same.
//
// Handshake rule for both ports: a beat transfers only on a rising clk edge
// where valid and ready are both high. The producer may hold valid high for
// any length of time. in_ready is high only in LOAD, so in_valid has no
// effect in the other states.
//
// Sequence: LOAD (3 input beats) -> SORT (3 cycles) -> EMIT (3 output beats).
// r_cnt has three uses: it is the write index in LOAD, the pass index in
// SORT, and the read index in EMIT.
module ordenador_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic [1:0]       o_dbg_state
);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SORT = 2'd1,
    EMIT = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_cnt;
  logic [1:0]       w_cnt_nxt;
  logic [WIDTH-1:0] r_val0;
  logic [WIDTH-1:0] r_val1;
  logic [WIDTH-1:0] r_val2;
  logic [WIDTH-1:0] w_lo;
  logic [WIDTH-1:0] w_hi;
  logic             w_swap;
  logic             w_mid_pair;

  assign o_dbg_state = r_state;

  // Pass 1 compares (r1,r2). Passes 0 and 2 compare (r0,r1).
  assign w_mid_pair = (r_cnt == 2'd1);
  assign w_lo       = w_mid_pair ? r_val1 : r_val0;
  assign w_hi       = w_mid_pair ? r_val2 : r_val1;

  // Swap only when the strict order test fails, so equal values stay in place.
`ifdef ORDENADOR_SEQ_ASCEND_EN
  assign w_swap = (w_lo > w_hi);
`else
  assign w_swap = (w_lo < w_hi);
`endif

  // State and counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= LOAD;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state, counter and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    out_data    = '0;
    case (r_state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (r_cnt == 2'd2) begin
            w_cnt_nxt   = 2'd0;
            w_state_nxt = SORT;
          end else begin
            w_cnt_nxt = r_cnt + 2'd1;
          end
        end
      end
      SORT: begin
        if (r_cnt == 2'd2) begin
          w_cnt_nxt   = 2'd0;
          w_state_nxt = EMIT;
        end else begin
          w_cnt_nxt = r_cnt + 2'd1;
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        out_last  = (r_cnt == 2'd2);
        case (r_cnt)
          2'd0:    out_data = r_val0;
          2'd1:    out_data = r_val1;
          default: out_data = r_val2;
        endcase
        if (out_ready) begin
          if (r_cnt == 2'd2) begin
            w_cnt_nxt   = 2'd0;
            w_state_nxt = LOAD;
          end else begin
            w_cnt_nxt = r_cnt + 2'd1;
          end
        end
      end
      default: begin
        w_state_nxt = LOAD;
        w_cnt_nxt   = 2'd0;
      end
    endcase
  end

  // Value registers: loaded in LOAD, then compare-exchanged once per SORT cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_val0 <= '0;
      r_val1 <= '0;
      r_val2 <= '0;
    end else begin
      case (r_state)
        LOAD: begin
          if (in_valid) begin
            case (r_cnt)
              2'd0:    r_val0 <= in_data;
              2'd1:    r_val1 <= in_data;
              default: r_val2 <= in_data;
            endcase
          end
        end
        SORT: begin
          if (w_swap) begin
            if (w_mid_pair) begin
              r_val1 <= r_val2;
              r_val2 <= r_val1;
            end else begin
              r_val0 <= r_val1;
              r_val1 <= r_val0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ordenador_seq.sv
// tb_ordenador_seq: directed and random groups for ordenador_seq. The bench
// checks each group against a min/mid/max reference model. It follows the
// ORDENADOR_SEQ_ASCEND_EN macro in the same way the design does.
module tb_ordenador_seq;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_last;
  logic [1:0]   dbg_state;

  ordenador_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .o_dbg_state (dbg_state)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;
  int t3 = 0;
  logic [W-1:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic fail_timeout(input string tag);
    vectors++;
    miscompares++;
    $error("FAIL %s observed=timeout expected=handshake", tag);
  endtask

  // Reference model: find the largest, middle and smallest values with plain arithmetic.
  task automatic push_model(input int a, input int b, input int c);
    int mx, mn, md;
    mx = (a > b) ? a : b;
    mx = (mx > c) ? mx : c;
    mn = (a < b) ? a : b;
    mn = (mn < c) ? mn : c;
    md = a + b + c - mx - mn;
`ifdef ORDENADOR_SEQ_ASCEND_EN
    exp_q.push_back(W'(mn));
    exp_q.push_back(W'(md));
    exp_q.push_back(W'(mx));
`else
    exp_q.push_back(W'(mx));
    exp_q.push_back(W'(md));
    exp_q.push_back(W'(mn));
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_last", 32'(out_last), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_state", 32'(dbg_state), 0);
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic send_val(input logic [W-1:0] v);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data = v;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (in_ready) ok = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    t3 = cyc;
    if (!ok) fail_timeout("in_handshake");
  endtask

  task automatic send_group(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    send_val(a);
    send_val(b);
    send_val(c);
    push_model(int'(a), int'(b), int'(c));
  endtask

  // Drain one group. 'stall' holds out_ready low for that many EMIT cycles.
  // 'junk' drives in_valid with the value 12 through SORT and EMIT.
  task automatic expect_group(input int stall, input bit junk);
    logic [W-1:0] e[3];
    int n;
    out_ready = (stall == 0);
    if (junk) begin
      in_valid = 1'b1;
      in_data = W'(12);
    end
    n = 0;
    while (!out_valid && n < 50) begin
      if (junk) check("junk_in_ready_sort", 32'(in_ready), 0);
      tick();
      n++;
    end
    if (!out_valid) begin
      fail_timeout("out_valid_wait");
      in_valid = 1'b0;
      return;
    end
    check("latency", 32'(cyc - t3), 3);
    check("exp_q_depth", 32'(exp_q.size()), 3);
    for (int k = 0; k < 3; k++) e[k] = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    for (int s = 0; s < stall; s++) begin
      check("stall_valid", 32'(out_valid), 1);
      check("stall_data", 32'(out_data), 32'(e[0]));
      check("stall_last", 32'(out_last), 0);
      check("stall_in_ready", 32'(in_ready), 0);
      tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("beat_valid", 32'(out_valid), 1);
      check("beat_data", 32'(out_data), 32'(e[k]));
      check("beat_last", 32'(out_last), (k == 2) ? 1 : 0);
      if (k == 2) in_valid = 1'b0;
      tick();
    end
    out_ready = 1'b0;
    check("post_in_ready", 32'(in_ready), 1);
    check("post_out_valid", 32'(out_valid), 0);
  endtask

  // Directed steps followed by random groups.
  initial begin
    do_reset();

    send_group(4'd3, 4'd9, 4'd5);
    expect_group(0, 1'b0);

    send_group(4'd2, 4'd2, 4'd7);
    expect_group(0, 1'b0);
    send_group(4'd15, 4'd0, 4'd15);
    expect_group(0, 1'b0);

    send_group(4'd1, 4'd4, 4'd8);
    expect_group(5, 1'b0);

    send_group(4'd6, 4'd1, 4'd3);
    expect_group(2, 1'b1);

    send_val(4'd5);
    send_val(4'd7);
    do_reset();
    send_group(4'd4, 4'd11, 4'd0);
    expect_group(0, 1'b0);

    // Reset during SORT, then during EMIT: no stale beat may follow.
    send_group(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
    tick();
    do_reset();
    send_group(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
    tick();
    tick();
    tick();
    check("emit_before_reset", 32'(out_valid), 1);
    do_reset();
    send_group(4'd10, 4'd12, 4'd10);
    expect_group(1, 1'b0);

    for (int g = 0; g < 25; g++) begin
      send_group(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
      expect_group(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
